// File: rtl/mem_responder.sv
// Doubleword RAM responder: one request at a time over valid/ready, fixed
// access latency, registered response held until the requester takes it.
module mem_responder #(
  parameter logic [63:0] BASE       = 64'h0000_0000_8000_0000,
  parameter int          DEPTH_LOG2 = 12,
  parameter int          LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  // state  | meaning
  // S_IDLE | ready for a request
  // S_WAIT | request latched, latency counter running
  // S_RESP | response registers loaded, waiting for resp_ready

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int          WORDS     = 1 << DEPTH_LOG2;
  localparam logic [63:0] RAM_BYTES = 64'd8 << DEPTH_LOG2;
  localparam logic [3:0]  LAT_LOAD  = 4'(LATENCY - 1);

  state_t state, state_nxt;

  logic [3:0]            cnt;
  logic                  wr_q;
  logic                  err_q;
  logic [63:0]           wdata_q;
  logic [7:0]            wmask_q;
  logic [DEPTH_LOG2-1:0] idx_q;

  logic [63:0] mem [0:WORDS-1];

  logic [63:0] req_off;
  logic        req_oor;
  logic        accept;
  logic        commit;
  logic        resp_hs;

  // Offset compare is wrap-free: once addr >= BASE, off >= RAM_BYTES is
  // equivalent to addr >= BASE + RAM_BYTES taken in unbounded arithmetic.
  assign req_off = req_addr - BASE;
  assign req_oor = (req_addr < BASE) || (req_off >= RAM_BYTES);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (req_valid)  state_nxt = S_WAIT;
      S_WAIT: if (cnt == '0)  state_nxt = S_RESP;
      S_RESP: if (resp_ready) state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == S_IDLE);
    accept    = req_valid && (state == S_IDLE);
    commit    = (state == S_WAIT) && (cnt == '0);
    resp_hs   = (state == S_RESP) && resp_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt        <= '0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      idx_q      <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        wr_q    <= req_write;
        err_q   <= req_oor;
        wdata_q <= req_wdata;
        wmask_q <= req_wmask;
        idx_q   <= req_off[DEPTH_LOG2+2:3];
        cnt     <= LAT_LOAD;
      end else if ((state == S_WAIT) && (cnt != '0)) begin
        cnt <= cnt - 4'd1;
      end

      if (commit) begin
        resp_valid <= 1'b1;
        resp_err   <= err_q;
        resp_rdata <= (wr_q || err_q) ? 64'd0 : mem[idx_q];
      end else if (resp_hs) begin
        resp_valid <= 1'b0;
        resp_err   <= 1'b0;
        resp_rdata <= '0;
      end
    end
  end

  // RAM has no reset; a reset on the commit edge drops the write.
  always_ff @(posedge clk) begin
    if (rst && commit && wr_q && !err_q) begin
      for (int b = 0; b < 8; b++) begin
        if (wmask_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a word-array reference model.
module tb_mem_responder;

  localparam logic [63:0] BASE       = 64'h0000_0000_8000_0000;
  localparam int          DEPTH_LOG2 = 12;
  localparam int          LATENCY    = 2;
  localparam logic [63:0] LIMIT      = BASE + (64'd8 << DEPTH_LOG2);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_wmask = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_rdata;
  logic        resp_err;

  int total = 0;
  int bad   = 0;

  logic [63:0] model [longint];

  int          pool_idx [8] = '{0, 1, 2, 3, 4, 5, 511, 4095};
  logic [63:0] oor_addr [6] = '{64'h7FFF_FFF8, 64'h8000_8000, 64'h0,
                                64'hFFFF_FFFF_FFFF_FFF8, 64'h8000_8007,
                                64'h8000_0000_8000_0000};

  mem_responder #(.BASE(BASE), .DEPTH_LOG2(DEPTH_LOG2), .LATENCY(LATENCY)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wmask  (req_wmask),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: range check and byte merge straight from the address map.
  task automatic model_access(input logic wr, input logic [63:0] addr, input logic [63:0] wd,
                              input logic [7:0] wm, output logic [63:0] exp_rd,
                              output logic exp_err);
    longint idx;
    logic [63:0] w;
    exp_err = (addr < BASE) || (addr >= LIMIT);
    exp_rd  = '0;
    if (!exp_err) begin
      idx = longint'((addr - BASE) / 8);
      w = model.exists(idx) ? model[idx] : 64'd0;
      if (wr) begin
        for (int b = 0; b < 8; b++) if (wm[b]) w[8*b +: 8] = wd[8*b +: 8];
        model[idx] = w;
      end else begin
        exp_rd = w;
      end
    end
  endtask

  // Entered and left just after a negedge with the DUT idle.
  task automatic do_txn(input string tag, input logic wr, input logic [63:0] addr,
                        input logic [63:0] wd, input logic [7:0] wm, input int hold);
    logic [63:0] exp_rd;
    logic        exp_err;
    logic [63:0] rd0;
    logic        err0;
    int          k;
    model_access(wr, addr, wd, wm, exp_rd, exp_err);
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = addr;
    req_wdata  = wd;
    req_wmask  = wm;
    resp_ready = (hold == 0);
    chk({tag, ".ready_idle"}, 64'(req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    k = 0;
    chk({tag, ".ready_wait"}, 64'(req_ready), 64'd0);
    while (!resp_valid && k < 40) begin
      req_valid = 1'($urandom);
      req_write = 1'($urandom);
      req_addr  = {$urandom, $urandom};
      req_wmask = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    chk({tag, ".latency"}, 64'(k), 64'(LATENCY));
    chk({tag, ".err"}, 64'(resp_err), 64'(exp_err));
    chk({tag, ".rdata"}, resp_rdata, exp_rd);
    rd0  = resp_rdata;
    err0 = resp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, ".hold_valid"}, 64'(resp_valid), 64'd1);
      chk({tag, ".hold_rdata"}, resp_rdata, rd0);
      chk({tag, ".hold_err"}, 64'(resp_err), 64'(err0));
      chk({tag, ".hold_ready"}, 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, ".done_valid"}, 64'(resp_valid), 64'd0);
    chk({tag, ".done_ready"}, 64'(req_ready), 64'd1);
    chk({tag, ".done_rdata"}, resp_rdata, 64'd0);
    chk({tag, ".done_err"}, 64'(resp_err), 64'd0);
  endtask

  initial begin
    logic [63:0] a;
    logic [63:0] wd;
    logic [7:0]  wm;

    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk("rst.req_ready", 64'(req_ready), 64'd1);
    chk("rst.resp_valid", 64'(resp_valid), 64'd0);
    chk("rst.resp_rdata", resp_rdata, 64'd0);
    chk("rst.resp_err", 64'(resp_err), 64'd0);

    foreach (pool_idx[i]) begin
      wd = (pool_idx[i] == 4) ? 64'd0 : {$urandom, $urandom};
      do_txn("init", 1'b1, BASE + 64'(pool_idx[i]) * 8, wd, 8'hFF, 0);
    end

    do_txn("wr_full", 1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 0);
    do_txn("rd_full", 1'b0, 64'h8000_0013, 64'h0, 8'h00, 0);
    chk("rd_full.abs", model[2], 64'h1122_3344_5566_7788);
    do_txn("wr_part", 1'b1, 64'h8000_0010, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 0);
    do_txn("rd_part", 1'b0, 64'h8000_0010, 64'h0, 8'h00, 0);
    chk("rd_part.abs", model[2], 64'h1122_3344_AAAA_AAAA);
    do_txn("wr_nomask", 1'b1, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 0);
    do_txn("rd_nomask", 1'b0, 64'h8000_0010, 64'h0, 8'h00, 0);
    do_txn("rd_low_oor", 1'b0, 64'h7FFF_FFF8, 64'h0, 8'h00, 0);
    do_txn("wr_high_oor", 1'b1, 64'h8000_8000, 64'h5555_5555_5555_5555, 8'hFF, 0);
    do_txn("rd_word0", 1'b0, 64'h8000_0000, 64'h0, 8'h00, 0);
    do_txn("rd_lastword", 1'b0, 64'h8000_7FF8, 64'h0, 8'h00, 0);
    do_txn("backpressure", 1'b0, 64'h8000_0010, 64'h0, 8'h00, 5);

    // Reset lands on the commit edge: the write must be dropped.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 64'h8000_0020;
    req_wdata = 64'hDEAD;
    req_wmask = 8'hFF;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk("midrst.resp_valid", 64'(resp_valid), 64'd0);
    chk("midrst.req_ready", 64'(req_ready), 64'd1);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("midrst.quiet", 64'(resp_valid), 64'd0);
    end
    do_txn("midrst_rd", 1'b0, 64'h8000_0020, 64'h0, 8'h00, 0);
    chk("midrst.abs", model[4], 64'd0);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 5) == 0)
        a = oor_addr[$urandom_range(0, 5)];
      else
        a = BASE + 64'(pool_idx[$urandom_range(0, 7)]) * 8 + 64'($urandom_range(0, 7));
      wd = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       wm = 8'hFF;
        1:       wm = 8'h00;
        default: wm = 8'($urandom);
      endcase
      do_txn("rand", 1'($urandom), a, wd, wm, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
